// File: rtl/mnk_pkg.sv
// Shared types for the m,n,k game engine.
package mnk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } mnk_state_t;

  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_P1   = 2'd1,
    W_P2   = 2'd2,
    W_DRAW = 2'd3
  } mnk_winner_t;

endpackage

// File: rtl/mnk_line_check.sv
// Combinational K-in-a-row detector around one cell of an N x N board.
// Checks every K-long run through (row, col) along the row, column,
// diagonal and anti-diagonal; runs that would leave the board are ignored,
// so nothing wraps between rows or columns.
module mnk_line_check
  import mnk_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned RW = $clog2(N),
  localparam int unsigned IW = $clog2(N*N)
) (
  input  logic [N*N-1:0] board,
  input  logic [RW-1:0]  row,
  input  logic [RW-1:0]  col,
  output logic           hit
);

  localparam int NS = int'(N);
  localparam int KS = int'(K);

  // Scan all four directions and all K alignments of the run on the cell.
  always_comb begin
    int   r;
    int   c;
    int   dr;
    int   dc;
    logic run_ok;
    hit = 1'b0;
    for (int d = 0; d < 4; d++) begin
      dr = (d == 0) ? 0 : 1;
      dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      for (int s = 0; s < KS; s++) begin
        run_ok = 1'b1;
        for (int i = 0; i < KS; i++) begin
          r = int'(row) + (i - s) * dr;
          c = int'(col) + (i - s) * dc;
          if (r < 0 || r >= NS || c < 0 || c >= NS) begin
            run_ok = 1'b0;
          end else if (!board[IW'(r * NS + c)]) begin
            run_ok = 1'b0;
          end
        end
        if (run_ok) begin
          hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mnk_game_engine.sv
// N x N, K-in-a-row two-player game controller.
// A move strobe is judged in PLAY; the placed cell is checked for a win in
// CHECK on the following cycle, then the game ends or the turn passes.
module mnk_game_engine
  import mnk_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned CW = $clog2(N*N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           first_p2,
  input  logic           move_valid,
  input  logic [CW-1:0]  move_idx,
  output logic           move_accept,
  output logic           move_reject,
  output logic           cur_player,
  output logic [N*N-1:0] p1_cells,
  output logic [N*N-1:0] p2_cells,
  output logic           game_over,
  output logic [1:0]     winner
);

  localparam int unsigned CELLS = N * N;
  localparam int unsigned RW    = $clog2(N);
  localparam int unsigned CNTW  = $clog2(N*N + 1);

  mnk_state_t       state;
  mnk_state_t       state_d;
  mnk_winner_t      winner_q;
  mnk_winner_t      winner_d;
  logic [CELLS-1:0] p1_d;
  logic [CELLS-1:0] p2_d;
  logic [CNTW-1:0]  count;
  logic [CNTW-1:0]  count_d;
  logic [RW-1:0]    last_row;
  logic [RW-1:0]    last_col;
  logic [RW-1:0]    row_d;
  logic [RW-1:0]    col_d;
  logic             cur_d;
  logic             accept_d;
  logic             reject_d;
  logic             game_over_d;

  logic [RW-1:0]    idx_row;
  logic [RW-1:0]    idx_col;
  logic             idx_in_range;
  logic             cell_taken;
  logic [CELLS-1:0] check_board;
  logic             line_hit;

  assign idx_row      = RW'(move_idx / CW'(N));
  assign idx_col      = RW'(move_idx % CW'(N));
  assign idx_in_range = (32'(move_idx) < CELLS);
  assign cell_taken   = p1_cells[move_idx] | p2_cells[move_idx];
  assign check_board  = cur_player ? p2_cells : p1_cells;
  assign winner       = winner_q;

  // Win detector on the mover's board around the last placed cell.
  mnk_line_check #(
    .N (N),
    .K (K)
  ) u_line_check (
    .board (check_board),
    .row   (last_row),
    .col   (last_col),
    .hit   (line_hit)
  );

  // Next-state and next-register logic; start overrides everything.
  always_comb begin
    state_d     = state;
    p1_d        = p1_cells;
    p2_d        = p2_cells;
    count_d     = count;
    row_d       = last_row;
    col_d       = last_col;
    cur_d       = cur_player;
    winner_d    = winner_q;
    game_over_d = game_over;
    accept_d    = 1'b0;
    reject_d    = 1'b0;
    if (start) begin
      state_d     = PLAY;
      p1_d        = '0;
      p2_d        = '0;
      count_d     = '0;
      cur_d       = first_p2;
      winner_d    = W_NONE;
      game_over_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (move_valid) begin
            reject_d = 1'b1;
          end
        end
        PLAY: begin
          if (move_valid) begin
            if (idx_in_range && !cell_taken) begin
              if (cur_player) begin
                p2_d[move_idx] = 1'b1;
              end else begin
                p1_d[move_idx] = 1'b1;
              end
              count_d  = count + 1'b1;
              row_d    = idx_row;
              col_d    = idx_col;
              accept_d = 1'b1;
              state_d  = CHECK;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (move_valid) begin
            reject_d = 1'b1;
          end
          if (line_hit) begin
            state_d     = DONE;
            game_over_d = 1'b1;
            winner_d    = cur_player ? W_P2 : W_P1;
          end else if (count == CNTW'(CELLS)) begin
            state_d     = DONE;
            game_over_d = 1'b1;
            winner_d    = W_DRAW;
          end else begin
            state_d = PLAY;
            cur_d   = ~cur_player;
          end
        end
        DONE: begin
          if (move_valid) begin
            reject_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Boards, move counter, last-move position and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_cells    <= '0;
      p2_cells    <= '0;
      count       <= '0;
      last_row    <= '0;
      last_col    <= '0;
      cur_player  <= 1'b0;
      winner_q    <= W_NONE;
      game_over   <= 1'b0;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
    end else begin
      p1_cells    <= p1_d;
      p2_cells    <= p2_d;
      count       <= count_d;
      last_row    <= row_d;
      last_col    <= col_d;
      cur_player  <= cur_d;
      winner_q    <= winner_d;
      game_over   <= game_over_d;
      move_accept <= accept_d;
      move_reject <= reject_d;
    end
  end

endmodule
